// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and types for the instruction fetch line buffer
package fetch_pkg;

    localparam logic [4:0] IMISS_RQ     = 5'b10000;
    localparam logic [3:0] IFILL_RET    = 4'h1;
    localparam logic [2:0] MSG_SIZE_16B = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd1,
        REQ  = 2'd2
    } fetch_state_t;

    typedef logic [3:0][31:0] fetch_line_t;

endpackage

// File: rtl/fetch_word_sel.sv
// rtl/fetch_word_sel.sv - word select from a 16-byte line; FETCH_BYTESWAP_EN byte-reverses the word
module fetch_word_sel
    import fetch_pkg::*;
(
    input  fetch_line_t line,
    input  logic [1:0]  offset,
    output logic [31:0] word
);

    logic [31:0] raw;

    assign raw = line[offset];

`ifdef FETCH_BYTESWAP_EN
    // L1.5 delivers big-endian words; decode expects little-endian
    assign word = {raw[7:0], raw[15:8], raw[23:16], raw[31:24]};
`else
    assign word = raw;
`endif

endmodule

// File: rtl/fetch_line_buffer.sv
// rtl/fetch_line_buffer.sv - one-line fetch buffer with IMISS/IFILL refill; FETCH_BYTESWAP_EN swaps word bytes
module fetch_line_buffer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        instr_valid_o,
    output logic [1:0]  state_o,
    output logic [4:0]  transducer_l15_rqtype,
    output logic [2:0]  transducer_l15_size,
    output logic [31:0] transducer_l15_address,
    output logic [31:0] transducer_l15_data,
    output logic        transducer_l15_val,
    input  logic        l15_transducer_ack,
    input  logic        l15_transducer_header_ack,
    input  logic        l15_transducer_val,
    input  logic [3:0]  l15_transducer_returntype,
    input  logic [63:0] l15_transducer_data_0,
    input  logic [63:0] l15_transducer_data_1,
    output logic        transducer_l15_req_ack
);

    fetch_state_t state;
    logic [31:0]  fetch_pc;
    fetch_line_t  line;
    logic [27:0]  line_tag;
    logic         line_valid;
    logic [27:0]  req_tag;
    logic         hit;
    logic [31:0]  word;
    logic         fill;
    logic         unused;

    // header_ack alone governs request acceptance
    assign unused = ^{l15_transducer_ack, redirect_pc[1:0]};

    assign hit  = line_valid && (fetch_pc[31:4] == line_tag);
    assign fill = (state == RESP) && l15_transducer_val && (l15_transducer_returntype == IFILL_RET);

    fetch_word_sel u_word_sel (
        .line   (line),
        .offset (fetch_pc[3:2]),
        .word   (word)
    );

    assign state_o                = state;
    assign transducer_l15_address = {req_tag, 4'h0};
    assign transducer_l15_data    = 32'h0;

    // Non-IFILL responses in RESP and stray responses in IDLE are consumed and dropped
    assign transducer_l15_req_ack = nrst && l15_transducer_val && ((state == IDLE) || (state == RESP));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state                 <= IDLE;
            fetch_pc              <= RESET_PC;
            line                  <= '0;
            line_tag              <= '0;
            line_valid            <= 1'b0;
            req_tag               <= '0;
            instr_o               <= '0;
            pc_o                  <= '0;
            instr_valid_o         <= 1'b0;
            transducer_l15_val    <= 1'b0;
            transducer_l15_rqtype <= '0;
            transducer_l15_size   <= '0;
        end else begin
            if (redirect) begin
                fetch_pc      <= {redirect_pc[31:2], 2'b00};
                instr_valid_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!redirect) begin
                        if (hit) begin
                            if (!stall) begin
                                instr_o       <= word;
                                pc_o          <= fetch_pc;
                                instr_valid_o <= 1'b1;
                                fetch_pc      <= fetch_pc + 32'd4;
                            end
                        end else begin
                            state                 <= REQ;
                            req_tag               <= fetch_pc[31:4];
                            transducer_l15_val    <= 1'b1;
                            transducer_l15_rqtype <= IMISS_RQ;
                            transducer_l15_size   <= MSG_SIZE_16B;
                            if (!stall) begin
                                instr_valid_o <= 1'b0;
                            end
                        end
                    end
                end

                REQ: begin
                    if (!stall) begin
                        instr_valid_o <= 1'b0;
                    end
                    if (l15_transducer_header_ack) begin
                        transducer_l15_val <= 1'b0;
                        state              <= RESP;
                    end
                end

                RESP: begin
                    if (!stall) begin
                        instr_valid_o <= 1'b0;
                    end
                    if (fill) begin
                        line       <= {l15_transducer_data_1[31:0], l15_transducer_data_1[63:32],
                                       l15_transducer_data_0[31:0], l15_transducer_data_0[63:32]};
                        line_tag   <= req_tag;
                        line_valid <= 1'b1;
                        state      <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fetch_line_buffer.md
Name: fetch_line_buffer

Overview:
Instruction-fetch front end that sits between the core's L1.5 instruction-side port and the decode stage. It holds one 16-byte instruction line and serves 32-bit instructions with their PCs to decode, one per cycle. On a line miss it issues an OpenPiton IMISS request and refills the line from the IFILL response. It honours decode stall and branch/jump redirect, and exposes its request state so the cache arbiter can tell when a response is still outstanding.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset.

Ports:
clk  in  1  clock
nrst  in  1  reset
stall  in  1  decode not ready; hold outputs
redirect  in  1  branch/jump taken, one-cycle pulse
redirect_pc  in  32  new fetch address; bits [1:0] ignored
instr_o  out  32  instruction to decode
pc_o  out  32  PC of instr_o
instr_valid_o  out  1  instr_o/pc_o valid
state_o  out  2  0=IDLE, 1=RESP, 2=REQ
transducer_l15_rqtype  out  5  request type
transducer_l15_size  out  3  request size
transducer_l15_address  out  32  request address
transducer_l15_data  out  32  request data, always 0
transducer_l15_val  out  1  request valid
l15_transducer_ack  in  1  request accepted (ignored; header_ack governs)
l15_transducer_header_ack  in  1  request header accepted
l15_transducer_val  in  1  response valid
l15_transducer_returntype  in  4  response type
l15_transducer_data_0  in  64  response bytes 0-7
l15_transducer_data_1  in  64  response bytes 8-15
transducer_l15_req_ack  out  1  response consumed

Behaviour:
- Reset: clk is the clock; reset is nrst, asynchronous, active-low.
  - On reset: fetch_pc=RESET_PC, line_valid=0, state IDLE, all outputs 0.
  - Reset mid-transaction abandons it. A response arriving later in IDLE is acked and discarded.
- Hit test: line_valid && fetch_pc[31:4]==line_tag.
- IDLE:
  - Hit && !stall: next cycle instr_o=word[fetch_pc[3:2]], pc_o=fetch_pc, instr_valid_o=1; fetch_pc+=4. Hit latency is 1 cycle.
  - Miss: go to REQ; instr_valid_o=0 next cycle, unless stall is held, in which case outputs hold.
- REQ:
  - Drive val=1, rqtype=IMISS_RQ (5'b10000), size=MSG_SIZE_16B (3'b101), address={fetch_pc[31:4],4'h0}.
  - All request fields stay stable until header_ack is sampled 1; then go to RESP with val=0 the same edge.
- RESP:
  - On l15_transducer_val with returntype==IFILL_RET (4'h1): req_ack=1 combinationally that cycle. Capture the line; line_tag=address[31:4]; line_valid=1; go to IDLE.
  - Any other returntype: ack, discard, stay in RESP.
- req_ack is 0 in all other cases, except IDLE stray responses, which are acked.
- Line word mapping (big-endian L1.5):
  - word0=data_0[63:32], word1=data_0[31:0], word2=data_1[63:32], word3=data_1[31:0].
- Redirect (highest priority):
  - fetch_pc<={redirect_pc[31:2],2'b0}; instr_valid_o<=0 next cycle, even under stall.
  - In REQ/RESP the in-flight request is never withdrawn. The refill still completes and fills the line; the hit test then uses the new fetch_pc.
- Simultaneous events:
  - Redirect + hit issue: redirect wins, no issue.
  - Redirect + response: the line is filled and the PC is updated in the same cycle.
- Line wrap: fetch_pc crossing a 16-byte boundary misses and triggers a refill. 32-bit PC overflow wraps to 0.

Optional Feature:
FETCH_BYTESWAP_EN:
- Defined: each 32-bit word is byte-reversed before output ({b0,b1,b2,b3}), converting L1.5 big-endian data to RISC-V little-endian.
- Undefined: words pass through unmodified.

Decomposition:
- Package fetch_pkg holds:
  - constants IMISS_RQ, IFILL_RET, MSG_SIZE_16B;
  - typedef enum logic[1:0] fetch_state_t {IDLE=0, RESP=1, REQ=2};
  - typedef logic[3:0][31:0] fetch_line_t.
- One sub-module, fetch_word_sel: combinational word select from line + offset, with optional byteswap.

Test Plan:
1. Reset, RESET_PC=0 -> REQ with address=0x0, rqtype=5'h10, size=3'h5. header_ack after 3 cycles -> val drops, state_o=1. IFILL response data_0=0x00000013_00100093, data_1=0x00200113_00300193 -> req_ack same cycle; next 4 cycles instr_valid_o=1 with pc_o 0x0,0x4,0x8,0xC. Without byteswap, instr_o is 0x00000013, 0x00100093, 0x00200113, 0x00300193.
2. Sequential fetch reaches 0x10 -> new request at address 0x10; instr_valid_o=0 until refill.
3. stall held 5 cycles at pc_o=0x4 -> instr_o/pc_o unchanged, fetch_pc stays 0x8; release -> 0x8 issues next cycle.
4. redirect to 0x107 while in RESP for line 0x20 -> instr_valid_o=0 next cycle; line 0x20 fills; miss then issues request at address 0x100; first instruction out has pc_o=0x104.
5. Response with returntype=4'h0 in RESP -> req_ack=1, discarded, state_o stays 1; subsequent IFILL completes normally.
6. nrst asserted in RESP -> outputs 0 immediately; a later stray response in IDLE -> req_ack=1, line_valid stays 0, new request issued at RESET_PC.
